btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Set-associative successor to the direct-mapped branch target buffer in the fetch stage.
- Each set covers one fetch line. Each way holds one branch at a given fetch offset.
- Several branches in the same fetch line sit in separate ways, so a separate "multiple" side array is not needed.
- Lookup has 1-cycle latency, and the tag compare is done after the array register so the array infers as synchronous RAM. Update is single-port style, with a per-set round-robin victim.

Parameters:
NUM_SETS, 32, number of sets; power of two, at least 2.
NUM_WAYS, 4, ways per set; power of two, 1 to 8.
TAG_BITS, `BTB_TAG_SIZE, stored source-tag width.
OFF_BITS, $bits(FetchOff_t), halfword offset width within a fetch line.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IN_pcValid  in  1  lookup request this cycle
IN_pc  in  31  fetch PC[31:1]
OUT_branch  out  PredBranch  prediction for the PC registered on the previous cycle
IN_btUpdate  in  BTUpdate  train/clean request; uses valid, clean, src, dst, btype, compressed
OUT_initDone  out  1  high once the invalidation sweep has finished

Behaviour:
- Address fields, from a halfword PC:
  - offs = pc[OFF_BITS-1:0]
  - set = pc[OFF_BITS +: log2(NUM_SETS)]
  - tag = pc[OFF_BITS+log2(NUM_SETS) +: TAG_BITS]
  - For update, use src[31:1] sliced the same way.
- Entry fields: valid, tag, offs, dst[30:0], btype, compr.
- Reset:
  - rst clears OUT_initDone, zeroes the sweep counter and zeroes all round-robin pointers.
  - The sweep then writes valid=0 to every way of set k on cycle k, taking NUM_SETS cycles; OUT_initDone rises on the following cycle.
  - Asserting rst mid-sweep or mid-operation restarts the sweep from set 0.
  - Updates are ignored until OUT_initDone=1.
  - OUT_branch.valid=0 from reset until the first lookup that follows the sweep.
- Lookup:
  - If IN_pcValid, register the whole set (all ways) plus IN_pc.
  - If !IN_pcValid, hold the registered state, so OUT_branch repeats.
- Hit logic, combinational from the registered set. Way w hits when valid && tag match && entry.offs >= registered offs.
  - No hits: OUT_branch.valid=0, other fields don't-care.
  - Otherwise select the hit with the smallest offs; on equal offs the lowest way index wins.
  - Outputs: valid=1, dst, btype, compr, offs from the selected way; taken = btype is BT_CALL or BT_JUMP; dirOnly=0.
  - multiple=1 iff at least one other hit has a larger offs.
- Update (valid && initDone), applied at the clock edge:
  - clean=1: invalidate every way in src's set whose tag and offs match src. The pointer is unchanged.
  - clean=0, existing way matching tag and offs: overwrite that way. The pointer is unchanged.
  - clean=0, no match, an invalid way exists: write the lowest-index invalid way.
  - clean=0, otherwise: write way ptr[set], then ptr[set] = ptr[set]+1 modulo NUM_WAYS.
- Lookup and update to the same set in the same cycle: the lookup sees the pre-update contents (read-before-write), unless the optional feature below is compiled in.
- Update and rst in the same cycle: rst wins and the update is dropped.
- NUM_WAYS=1 degenerates to a direct-mapped BTB with multiple always 0.

Optional Feature:
- Macro: BTB_UPDATE_BYPASS_EN.
- Defined: when a training update (clean=0) and a lookup target the same set in the same cycle, the written entry is merged into the registered set image, so the next cycle's OUT_branch reflects the update. A clean update bypasses an invalidation the same way.
- Undefined: strict read-before-write. The new entry becomes visible one lookup later.

Test Plan:
- Reset sweep: rst 1 cycle with NUM_SETS=32 -> OUT_initDone=0 for 32 cycles, then 1; any lookup during the sweep returns valid=0.
- Single branch: update src=0x1006, dst=0x2000, BT_JUMP; lookup pc=0x1000>>1 -> next cycle valid=1, dst=0x1000 (31-bit), offs=3, taken=1, multiple=0. Lookup of the pc for 0x1008 -> valid=0.
- Two branches in one line: train offs 2 (BT_BRANCH) and offs 6 (BT_CALL); lookup at offs 0 -> offs=2, multiple=1, taken=0. Lookup at offs 3 -> offs=6, multiple=0, taken=1.
- Replacement: 5 distinct tags into one set with NUM_WAYS=4 -> the 5th write overwrites way 0 and the pointer becomes 1; the first tag now misses and tags 2-5 hit.
- Clean: train then clean the same src -> lookup valid=0; other ways of the set still hit.
- Same-cycle lookup and update to one set: valid=0 next cycle without the bypass macro; valid=1 with the correct dst when BTB_UPDATE_BYPASS_EN is defined.

Source files
------------

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer; optional BTB_UPDATE_BYPASS_EN merges same-cycle updates into lookups

module btb_assoc #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 4,
    parameter int TAG_BITS = 12,
    parameter int OFF_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IN_pcValid,
    input  logic [30:0]         IN_pc,
    output logic                OUT_branch_valid,
    output logic [30:0]         OUT_branch_dst,
    output logic [OFF_BITS-1:0] OUT_branch_offs,
    output logic [1:0]          OUT_branch_btype,
    output logic                OUT_branch_compr,
    output logic                OUT_branch_taken,
    output logic                OUT_branch_dirOnly,
    output logic                OUT_branch_multiple,
    input  logic                IN_btUpdate_valid,
    input  logic                IN_btUpdate_clean,
    input  logic [31:0]         IN_btUpdate_src,
    input  logic [31:0]         IN_btUpdate_dst,
    input  logic [1:0]          IN_btUpdate_btype,
    input  logic                IN_btUpdate_compressed,
    output logic                OUT_initDone
);

    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [1:0] BT_CALL = 2'd1;
    localparam logic [1:0] BT_JUMP = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [OFF_BITS-1:0] offs;
        logic [30:0]         dst;
        logic [1:0]          btype;
        logic                compr;
    } entry_t;

    typedef entry_t [NUM_WAYS-1:0] set_t;

    set_t mem [NUM_SETS];

    logic                init_done_q, init_done_d;
    logic [SET_BITS-1:0] sweep_q, sweep_d;
    logic [WAY_BITS-1:0] ptr_q [NUM_SETS];
    logic [WAY_BITS-1:0] ptr_d [NUM_SETS];
    logic                rd_valid_q, rd_valid_d;
    logic [TAG_BITS-1:0] rd_tag_q, rd_tag_d;
    logic [OFF_BITS-1:0] rd_offs_q, rd_offs_d;
    set_t                rd_set_q, rd_set_d;

    logic [SET_BITS-1:0] l_set, u_set;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic [OFF_BITS-1:0] l_offs, u_offs;
    logic [30:0]         u_hw;
    set_t                u_cur;
    entry_t              new_ent;
    logic [NUM_WAYS-1:0] wr_ways;
    logic [NUM_WAYS-1:0] hit;
    entry_t              best;
    logic                any_hit, multiple;
    logic                unused_bits;

    assign unused_bits = ^{IN_pc, IN_btUpdate_src, IN_btUpdate_dst};

    assign u_hw   = IN_btUpdate_src[31:1];
    assign l_offs = IN_pc[OFF_BITS-1:0];
    assign l_set  = IN_pc[OFF_BITS +: SET_BITS];
    assign l_tag  = IN_pc[OFF_BITS+SET_BITS +: TAG_BITS];
    assign u_offs = u_hw[OFF_BITS-1:0];
    assign u_set  = u_hw[OFF_BITS +: SET_BITS];
    assign u_tag  = u_hw[OFF_BITS+SET_BITS +: TAG_BITS];

    // Invalidation sweep: one set per cycle until every set has been cleared.
    always_comb begin
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        if (!init_done_q) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == SET_BITS'(NUM_SETS - 1)) begin
                init_done_d = 1'b1;
            end
        end
    end

    // Update way selection: clean hits all matches, training prefers match, then free way, then round-robin victim.
    always_comb begin
        logic                found_match, found_free;
        logic [WAY_BITS-1:0] victim;
        logic [NUM_WAYS-1:0] match;
        u_cur         = mem[u_set];
        new_ent.valid = !IN_btUpdate_clean;
        new_ent.tag   = u_tag;
        new_ent.offs  = u_offs;
        new_ent.dst   = IN_btUpdate_dst[31:1];
        new_ent.btype = IN_btUpdate_btype;
        new_ent.compr = IN_btUpdate_compressed;
        wr_ways       = '0;
        ptr_d         = ptr_q;
        found_match   = 1'b0;
        found_free    = 1'b0;
        victim        = ptr_q[u_set];
        for (int w = 0; w < NUM_WAYS; w++) begin
            match[w] = u_cur[w].valid && (u_cur[w].tag == u_tag) && (u_cur[w].offs == u_offs);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!u_cur[w].valid) begin
                found_free = 1'b1;
                victim     = WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                found_match = 1'b1;
                victim      = WAY_BITS'(w);
            end
        end
        if (IN_btUpdate_valid && init_done_q && !rst) begin
            if (IN_btUpdate_clean) begin
                wr_ways = match;
            end else begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    wr_ways[w] = (WAY_BITS'(w) == victim);
                end
                if (!found_match && !found_free) begin
                    ptr_d[u_set] = (ptr_q[u_set] == WAY_BITS'(NUM_WAYS - 1)) ? '0 : ptr_q[u_set] + 1'b1;
                end
            end
        end
    end

    // Lookup capture: register the whole set on a request, hold it otherwise.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_tag_d   = rd_tag_q;
        rd_offs_d  = rd_offs_q;
        rd_set_d   = rd_set_q;
        if (IN_pcValid) begin
            rd_valid_d = init_done_q;
            rd_tag_d   = l_tag;
            rd_offs_d  = l_offs;
            rd_set_d   = mem[l_set];
`ifdef BTB_UPDATE_BYPASS_EN
            if (u_set == l_set) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (wr_ways[w]) begin
                        rd_set_d[w] = new_ent;
                    end
                end
            end
`endif
        end
    end

    // Hit selection: nearest branch at or after the fetch offset, lowest way on ties.
    always_comb begin
        any_hit  = 1'b0;
        multiple = 1'b0;
        best     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit[w] = rd_set_q[w].valid && (rd_set_q[w].tag == rd_tag_q) && (rd_set_q[w].offs >= rd_offs_q);
            if (hit[w] && (!any_hit || (rd_set_q[w].offs < best.offs))) begin
                any_hit = 1'b1;
                best    = rd_set_q[w];
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hit[w] && (rd_set_q[w].offs > best.offs)) begin
                multiple = 1'b1;
            end
        end
    end

    assign OUT_branch_valid    = rd_valid_q && any_hit;
    assign OUT_branch_dst      = best.dst;
    assign OUT_branch_offs     = best.offs;
    assign OUT_branch_btype    = best.btype;
    assign OUT_branch_compr    = best.compr;
    assign OUT_branch_taken    = (best.btype == BT_CALL) || (best.btype == BT_JUMP);
    assign OUT_branch_dirOnly  = 1'b0;
    assign OUT_branch_multiple = multiple;
    assign OUT_initDone        = init_done_q;

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q <= 1'b0;
            sweep_q     <= '0;
            rd_valid_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            init_done_q <= init_done_d;
            sweep_q     <= sweep_d;
            rd_valid_q  <= rd_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    // Registered lookup image; contents only matter once rd_valid_q is set.
    always_ff @(posedge clk) begin
        rd_tag_q  <= rd_tag_d;
        rd_offs_q <= rd_offs_d;
        rd_set_q  <= rd_set_d;
    end

    // Entry array writes: sweep clears a set, otherwise apply the selected update ways.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!init_done_q) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    mem[sweep_q][w] <= '0;
                end
            end else begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (wr_ways[w]) begin
                        mem[u_set][w] <= new_ent;
                    end
                end
            end
        end
    end

endmodule
